f_norm_sequencer: RTL and testbench
===================================

Name: f_norm_sequencer

Overview:
- Multi-cycle normaliser controller for the single-precision add/sub datapath.
- Takes a raw 25-bit significand result and its exponent, and finds the leading one using one instance of F_priority_encoder, a 23-bit input mapped to a 5-bit output.
- Shifts the significand, adjusts the exponent, and flags overflow, underflow and zero.
- Sits between the significand adder and result packing, with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8: exponent width. Only 8 is supported; an elaboration assertion enforces it.
- BIAS, 127: exponent bias. Used only to document the flush threshold; the max exponent is 2**EXP_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_sign  in  1  sign of result
- in_exp  in  EXP_W  biased exponent before normalisation
- in_mant  in  25  raw significand: bit24 = carry-out, bit23 = hidden-one position, bits[22:0] = fraction
- out_valid  out  1  normalised result valid
- out_ready  in  1  downstream accepts result
- out_sign  out  1  registered sign
- out_exp  out  EXP_W  normalised exponent
- out_frac  out  23  normalised fraction, hidden bit dropped
- out_ovf  out  1  overflow to infinity
- out_unf  out  1  underflow flushed to zero
- out_zero  out  1  result is exactly zero
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: async, active-high. FSM goes to IDLE; every output register clears to 0; in_ready=1 on the first cycle after reset deasserts. Reset mid-operation drops the in-flight beat silently.
- FSM states: IDLE, ENC, ADJ, OUT.
- IDLE: in_ready=1. On in_valid&&in_ready, capture sign, exp and mant, then go to ENC.
- ENC: register the encoder result lz_y = enc(mant[22:0]), then go to ADJ.
- ADJ: compute the result, then go to OUT. Cases are checked in priority order:
  - Special: exp==255 passes through; frac=mant[22:0], exp=255, no flags.
  - Carry: mant[24]=1 gives frac=mant[23:1] (truncate), exp+1. If exp+1==255: frac=0, out_ovf=1.
  - Normalised: mant[23]=1 gives frac=mant[22:0], exp unchanged.
  - Zero: mant==0 (lz_y==0) gives exp=0, frac=0, out_zero=1.
  - Left shift: sh = 24-lz_y (range 1..23), frac=(mant<<sh)[22:0], exp-sh.
  - Flush: if exp<=sh, set exp=0, frac=0, out_unf=1. Denormals are not produced.
- Exponent arithmetic: use EXP_W+1 bits internally; no wrap is permitted.
- OUT: out_valid=1, with outputs held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Handshake: in_ready is high only in IDLE, so there is no combinational path from out_ready to in_ready.
- Latency and throughput: accept at cycle 0, out_valid at cycle 3 for the full path. Best-case throughput is one beat per 4 cycles.
- Flags are mutually exclusive and are valid only while out_valid=1.

Optional Feature:
- Macro: F_NORM_BYPASS_EN.
- When defined: in IDLE, a beat with mant[24:23]==2'b01 or exp==255 skips ENC/ADJ and goes straight to OUT. out_valid is asserted at cycle 1.
- When undefined: every beat traverses ENC and ADJ, giving a fixed latency of 3.
- Results are bit-identical either way.

Decomposition:
- Shared package f_norm_pkg holds:
  - typedef enum logic [1:0] {IDLE, ENC, ADJ, OUT} norm_state_t
  - localparams MANT_W=23, EXP_MAX=8'hFF
  - a packed struct norm_res_t {sign, exp, frac, ovf, unf, zero}
- Sub-module: F_priority_encoder is instantiated unchanged. The shift/exponent-adjust logic stays inline; no further sub-module.

Test Plan:
- Normalised: exp=8'd130, mant=25'h0800001 -> out_exp=130, out_frac=23'h000001, flags 0; latency 3 (1 with F_NORM_BYPASS_EN).
- Carry: exp=8'd100, mant=25'h1000002 -> out_exp=101, out_frac=23'h000001. Then exp=8'd254, mant=25'h1000000 -> out_exp=255, out_frac=0, out_ovf=1.
- Left shift: exp=8'd50, mant=25'h0000010 -> lz_y=5, sh=19, out_exp=31, out_frac=0. Then exp=8'd10, same mant -> out_exp=0, out_unf=1.
- Zero/special: mant=0, exp=8'd77 -> out_zero=1, out_exp=0. Then exp=8'd255, mant=25'h0400000 -> out_exp=255, out_frac=23'h400000, flags 0.
- Backpressure/reset:
  - Hold out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0.
  - Assert reset while in ENC -> next cycle all outputs 0, busy=0, in_ready=1 after release.
  - A new beat then completes normally.

Source files
------------

// File: rtl/f_norm_pkg.sv
// Shared types and constants for the single-precision add/sub normaliser.
package f_norm_pkg;
  localparam int MANT_W = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, ENC, ADJ, OUT} norm_state_t;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] frac;
    logic              ovf;
    logic              unf;
    logic              zero;
  } norm_res_t;
endpackage

// File: rtl/f_norm_sequencer_if.sv
// Input/output handshake bundle of the normaliser; slave is the normaliser side.
interface f_norm_sequencer_if #(parameter int EXP_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [24:0]      in_mant;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [22:0]      out_frac;
  logic             out_ovf;
  logic             out_unf;
  logic             out_zero;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac, out_ovf, out_unf, out_zero
  );
  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac, out_ovf, out_unf, out_zero
  );
endinterface

// File: rtl/f_norm_sequencer_penc.sv
// Leading-one encoder: y = index+1 of the highest set bit of a, 0 when a is zero.
module F_priority_encoder (
  input  logic [22:0] a,
  output logic [4:0]  y
);
  always_comb begin
    y = '0;
    for (int i = 0; i < 23; i++)
      if (a[i]) y = 5'(i + 1);
  end
endmodule

// File: rtl/f_norm_sequencer.sv
// Multi-cycle normaliser: IDLE -> ENC -> ADJ -> OUT with valid/ready on both sides.
// F_NORM_BYPASS_EN lets already-normalised and special beats jump from IDLE to OUT.
module f_norm_sequencer
  import f_norm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int BIAS  = 127
) (
  input  logic               clk,
  input  logic               reset,
  f_norm_sequencer_if.slave  bus,
  output logic               busy
);
  if (EXP_W != 8 || BIAS != 127) begin : g_cfg_chk
    $error("f_norm_sequencer: only EXP_W=8 / BIAS=127 is supported");
  end

  norm_state_t state, state_nx;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [24:0] mant_q;
  logic [4:0]  lz_q, lz_y;
  norm_res_t   res_q, adj_res;

  logic [8:0]        e_inc, e_sub;
  logic [4:0]        sh;
  logic [MANT_W-1:0] shifted;

  F_priority_encoder u_penc (.a(mant_q[22:0]), .y(lz_y));

`ifdef F_NORM_BYPASS_EN
  logic      byp_hit;
  norm_res_t byp_res;
  assign byp_hit = (bus.in_exp == EXP_MAX) || (bus.in_mant[24:23] == 2'b01);
  assign byp_res = '{sign: bus.in_sign, exp: bus.in_exp, frac: bus.in_mant[22:0],
                     ovf: 1'b0, unf: 1'b0, zero: 1'b0};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      lz_q   <= '0;
      res_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        sign_q <= bus.in_sign;
        exp_q  <= bus.in_exp;
        mant_q <= bus.in_mant;
      end
      if (state == ENC) lz_q <= lz_y;
      if (state == ADJ) res_q <= adj_res;
`ifdef F_NORM_BYPASS_EN
      if (state == IDLE && bus.in_valid && byp_hit) res_q <= byp_res;
`endif
    end
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
`ifdef F_NORM_BYPASS_EN
          state_nx = byp_hit ? OUT : ENC;
`else
          state_nx = ENC;
`endif
        end
      end
      ENC: state_nx = ADJ;
      ADJ: state_nx = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Exponent math is one bit wider so a borrow in e_sub flags the flush case.
  always_comb begin
    e_inc   = {1'b0, exp_q} + 9'd1;
    sh      = 5'd24 - lz_q;
    e_sub   = {1'b0, exp_q} - {4'b0, sh};
    shifted = mant_q[22:0] << sh;
    adj_res      = '0;
    adj_res.sign = sign_q;
    if (exp_q == EXP_MAX) begin
      adj_res.exp  = EXP_MAX;
      adj_res.frac = mant_q[22:0];
    end else if (mant_q[24]) begin
      if (e_inc == {1'b0, EXP_MAX}) begin
        adj_res.exp = EXP_MAX;
        adj_res.ovf = 1'b1;
      end else begin
        adj_res.exp  = e_inc[7:0];
        adj_res.frac = mant_q[23:1];
      end
    end else if (mant_q[23]) begin
      adj_res.exp  = exp_q;
      adj_res.frac = mant_q[22:0];
    end else if (lz_q == 5'd0) begin
      adj_res.zero = 1'b1;
    end else if (e_sub[8] || e_sub == 9'd0) begin
      adj_res.unf = 1'b1;
    end else begin
      adj_res.exp  = e_sub[7:0];
      adj_res.frac = shifted;
    end
  end

  assign bus.out_sign = res_q.sign;
  assign bus.out_exp  = res_q.exp;
  assign bus.out_frac = res_q.frac;
  assign bus.out_ovf  = res_q.ovf;
  assign bus.out_unf  = res_q.unf;
  assign bus.out_zero = res_q.zero;
endmodule

// File: tb/tb_f_norm_sequencer.sv
// Self-checking bench for f_norm_sequencer: directed plan vectors, random beats, backpressure, reset.
module tb_f_norm_sequencer;
  import f_norm_pkg::*;

`ifdef F_NORM_BYPASS_EN
  localparam int BYP_LAT = 1;
`else
  localparam int BYP_LAT = 3;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  f_norm_sequencer_if #(.EXP_W(8)) bus ();
  f_norm_sequencer #(.EXP_W(8), .BIAS(127)) dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: IEEE-style normalisation rules computed directly from the value.
  function automatic norm_res_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
    norm_res_t r;
    int p, sh;
    logic [24:0] t;
    r = '0;
    r.sign = s;
    if (e == 8'hFF) begin
      r.exp = 8'hFF; r.frac = m[22:0];
    end else if (m[24]) begin
      if (int'(e) + 1 == 255) begin r.exp = 8'hFF; r.ovf = 1'b1; end
      else begin r.exp = e + 8'd1; r.frac = m[23:1]; end
    end else if (m[23]) begin
      r.exp = e; r.frac = m[22:0];
    end else if (m == 25'd0) begin
      r.zero = 1'b1;
    end else begin
      p = 0;
      for (int i = 0; i < 23; i++) if (m[i]) p = i;
      sh = 23 - p;
      if (int'(e) <= sh) r.unf = 1'b1;
      else begin
        r.exp = 8'(int'(e) - sh);
        t = m << sh;
        r.frac = t[22:0];
      end
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [7:0] e, input logic [24:0] m);
    int l = 3;
    if (e == 8'hFF || m[24:23] == 2'b01) l = BYP_LAT;
    return l;
  endfunction

  function automatic norm_res_t obs();
    norm_res_t r;
    r.sign = bus.out_sign; r.exp = bus.out_exp; r.frac = bus.out_frac;
    r.ovf = bus.out_ovf; r.unf = bus.out_unf; r.zero = bus.out_zero;
    return r;
  endfunction

  // Present one beat, return the result at the first out_valid and the cycle count to it.
  task automatic run_beat(input logic s, input logic [7:0] e, input logic [24:0] m,
                          output norm_res_t r, output int lat);
    int w = 0;
    while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    bus.in_valid = 1'b1; bus.in_sign = s; bus.in_exp = e; bus.in_mant = m;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r = obs();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #15;
    checks++;
    if ({bus.out_valid, busy, obs()} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {bus.out_valid, busy, obs()});
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: in_ready,busy got %b expected 10", {bus.in_ready, busy});
    end
  endtask

  task automatic test_directed();
    logic [7:0]  te[11];
    logic [24:0] tm[11];
    logic        ts[11];
    norm_res_t   tx[11];
    norm_res_t   r;
    int          lat;
    te[0]  = 8'd130; tm[0]  = 25'h0800001; ts[0]  = 0; tx[0]  = {1'b0, 8'd130, 23'h000001, 3'b000};
    te[1]  = 8'd100; tm[1]  = 25'h1000002; ts[1]  = 0; tx[1]  = {1'b0, 8'd101, 23'h000001, 3'b000};
    te[2]  = 8'd254; tm[2]  = 25'h1000000; ts[2]  = 0; tx[2]  = {1'b0, 8'd255, 23'h000000, 3'b100};
    te[3]  = 8'd50;  tm[3]  = 25'h0000010; ts[3]  = 0; tx[3]  = {1'b0, 8'd31,  23'h000000, 3'b000};
    te[4]  = 8'd10;  tm[4]  = 25'h0000010; ts[4]  = 0; tx[4]  = {1'b0, 8'd0,   23'h000000, 3'b010};
    te[5]  = 8'd77;  tm[5]  = 25'h0000000; ts[5]  = 0; tx[5]  = {1'b0, 8'd0,   23'h000000, 3'b001};
    te[6]  = 8'd255; tm[6]  = 25'h0400000; ts[6]  = 1; tx[6]  = {1'b1, 8'd255, 23'h400000, 3'b000};
    te[7]  = 8'd200; tm[7]  = 25'h0123456; ts[7]  = 1; tx[7]  = {1'b1, 8'd197, 23'h11A2B0, 3'b000};
    te[8]  = 8'd20;  tm[8]  = 25'h0000010; ts[8]  = 0; tx[8]  = {1'b0, 8'd1,   23'h000000, 3'b000};
    te[9]  = 8'd19;  tm[9]  = 25'h0000010; ts[9]  = 0; tx[9]  = {1'b0, 8'd0,   23'h000000, 3'b010};
    te[10] = 8'd3;   tm[10] = 25'h0000001; ts[10] = 1; tx[10] = {1'b1, 8'd0,   23'h000000, 3'b010};
    for (int i = 0; i < 11; i++) begin
      run_beat(ts[i], te[i], tm[i], r, lat);
      checks++;
      if (r !== tx[i]) begin
        errors++;
        $display("FAIL directed_%0d result: got %h expected %h", i, r, tx[i]);
      end
      checks++;
      if (lat !== exp_lat(te[i], tm[i])) begin
        errors++;
        $display("FAIL directed_%0d latency: got %0d expected %0d", i, lat, exp_lat(te[i], tm[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  e;
    logic [24:0] m;
    logic        s;
    norm_res_t   r, x;
    int          lat;
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom());
      e = 8'($urandom_range(0, 255));
      m = 25'($urandom());
      case ($urandom_range(0, 5))
        0: m[24:23] = 2'b01;
        1: m[24] = 1'b1;
        2: m = m >> $urandom_range(2, 24);
        3: m = '0;
        4: e = 8'hFF;
        default: begin e = 8'($urandom_range(250, 254)); m[24] = 1'b1; end
      endcase
      x = model(s, e, m);
      run_beat(s, e, m, r, lat);
      checks++;
      if (r !== x) begin
        errors++;
        $display("FAIL random_%0d result (e=%0d m=%h): got %h expected %h", i, e, m, r, x);
      end
      checks++;
      if (lat !== exp_lat(e, m)) begin
        errors++;
        $display("FAIL random_%0d latency: got %0d expected %0d", i, lat, exp_lat(e, m));
      end
    end
  endtask

  task automatic test_backpressure();
    norm_res_t snap;
    int w = 0;
    bus.in_valid = 1'b1; bus.in_sign = 1'b1; bus.in_exp = 8'd100; bus.in_mant = 25'h1000002;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (!bus.out_valid && w < 20) begin @(posedge clk); #1; w++; end
    snap = obs();
    checks++;
    if (snap !== {1'b1, 8'd101, 23'h000001, 3'b000}) begin
      errors++;
      $display("FAIL bp_result: got %h expected %h", snap, {1'b1, 8'd101, 23'h000001, 3'b000});
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, obs()} !== {2'b10, snap}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got %h expected %h", c, {bus.out_valid, bus.in_ready, obs()}, {2'b10, snap});
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: out_valid,in_ready got %b expected 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_reset_midop();
    norm_res_t r;
    int lat;
    bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_exp = 8'd50; bus.in_mant = 25'h0000010;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if ({busy, bus.in_ready, bus.out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL midop_in_enc: busy,in_ready,out_valid got %b expected 100", {busy, bus.in_ready, bus.out_valid});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, busy, obs()} !== 37'd0) begin
      errors++;
      $display("FAIL midop_reset_outputs: got %h expected 0", {bus.out_valid, busy, obs()});
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, busy, bus.out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL midop_release: in_ready,busy,out_valid got %b expected 100", {bus.in_ready, busy, bus.out_valid});
    end
    run_beat(1'b0, 8'd130, 25'h0800001, r, lat);
    checks++;
    if (r !== {1'b0, 8'd130, 23'h000001, 3'b000}) begin
      errors++;
      $display("FAIL midop_next_beat: got %h expected %h", r, {1'b0, 8'd130, 23'h000001, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] m[4];
    logic [7:0]  e[4];
    int          acc[4];
    int          w;
    norm_res_t   x;
    for (int i = 0; i < 4; i++) begin
      e[i] = 8'($urandom_range(1, 200));
      m[i] = 25'($urandom());
      m[i][24] = 1'b1;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_sign = 1'b0; bus.in_exp = e[i]; bus.in_mant = m[i];
      w = 0;
      while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
      acc[i] = cyc;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      w = 0;
      while (!bus.out_valid && w < 20) begin @(posedge clk); #1; w++; end
      x = model(1'b0, e[i], m[i]);
      checks++;
      if (obs() !== x) begin
        errors++;
        $display("FAIL b2b_%0d result: got %h expected %h", i, obs(), x);
      end
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] !== 4) begin
          errors++;
          $display("FAIL b2b_%0d interval: got %0d expected 4", i, acc[i] - acc[i-1]);
        end
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
